// File: rtl/pc_gen_unit.sv
// IF-stage program-counter generator: holds PC and PC+4, owns EPC and a
// circular return-address stack, and picks the next PC by fixed priority.
module pc_gen_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_4180),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             PcReSet,
    input  logic                             PCWrite,
    input  logic                             exc_req,
    input  logic [WIDTH-1:0]                 exc_pc,
    input  logic                             eret_req,
    input  logic                             redirect_valid,
    input  logic [WIDTH-1:0]                 redirect_pc,
    input  logic                             ras_push,
    input  logic [WIDTH-1:0]                 ras_push_addr,
    input  logic                             ras_pop,
    output logic [WIDTH-1:0]                 PCOut,
    output logic [WIDTH-1:0]                 PCOut_plus4,
    output logic [WIDTH-1:0]                 EPC,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_pop_hit
);

    localparam int               CW         = $clog2(RAS_DEPTH + 1);
    localparam int               PW         = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] RESET_PC   = RESET_VECTOR & ALIGN_MASK;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic [WIDTH-1:0] ras_top;
    logic             flush;
    logic             ras_en;
    logic             do_pop;
    logic             do_push;
    logic [WIDTH-1:0] next_pc;

    // ras_ptr addresses the next free slot; the top lives one below it.
    assign top_idx = ras_ptr - PW'(1);
    assign ras_top = ras_mem[top_idx];

    // Flushing sources freeze the RAS so a squashed call/return cannot corrupt it.
    assign flush       = exc_req | eret_req | redirect_valid;
    assign ras_en      = PCWrite & ~flush;
    assign do_pop      = ras_en & ras_pop & (ras_count != '0);
    assign do_push     = ras_en & ras_push;
    assign ras_pop_hit = do_pop;

    // Push together with a hit pop replaces the top in place.
    assign wr_idx = do_pop ? top_idx : ras_ptr;

    always_comb begin
        next_pc = PCOut;
        if (exc_req)
            next_pc = EXC_VECTOR & ALIGN_MASK;
        else if (eret_req)
            next_pc = EPC & ALIGN_MASK;
        else if (redirect_valid)
            next_pc = redirect_pc & ALIGN_MASK;
        else if (do_pop)
            next_pc = ras_top & ALIGN_MASK;
        else if (PCWrite)
            next_pc = PCOut_plus4;
    end

    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            PCOut       <= RESET_PC;
            PCOut_plus4 <= RESET_PC + WIDTH'(4);
            EPC         <= '0;
        end else begin
            PCOut       <= next_pc;
            PCOut_plus4 <= next_pc + WIDTH'(4);
            if (exc_req)
                EPC <= exc_pc;
        end
    end

    always_ff @(posedge clk or posedge PcReSet) begin
        if (PcReSet) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (do_push && !do_pop) begin
            ras_ptr <= ras_ptr + PW'(1);
            if (ras_count != CW'(RAS_DEPTH))
                ras_count <= ras_count + CW'(1);
        end else if (do_pop && !do_push) begin
            ras_ptr   <= top_idx;
            ras_count <= ras_count - CW'(1);
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push)
            ras_mem[wr_idx] <= ras_push_addr;
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed vector table, reset and WIDTH=16 wrap
// sequences, then random stimulus against a queue-based reference model.
module tb_pc_gen_unit;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic         pw, exc, eret, rd;
        logic [W-1:0] xpc, rpc;
        logic         push;
        logic [W-1:0] paddr;
        logic         pop;
        logic [W-1:0] e_pc, e_epc;
        int           e_cnt;
        logic         e_hit;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic PcReSet;
    always #5 clk = ~clk;

    logic          PCWrite, exc_req, eret_req, redirect_valid, ras_push, ras_pop;
    logic [W-1:0]  exc_pc, redirect_pc, ras_push_addr;
    logic [W-1:0]  PCOut, PCOut_plus4, EPC;
    logic [CW-1:0] ras_count;
    logic          ras_pop_hit;

    logic          w16, zero1;
    logic [15:0]   zero16, pc16, pc16_p4, epc16;
    logic [2:0]    cnt16;
    logic          hit16;

    pc_gen_unit #(.WIDTH(W), .RAS_DEPTH(DEPTH)) u_dut (
        .clk(clk), .PcReSet(PcReSet), .PCWrite(PCWrite), .exc_req(exc_req),
        .exc_pc(exc_pc), .eret_req(eret_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ras_push(ras_push), .ras_push_addr(ras_push_addr),
        .ras_pop(ras_pop), .PCOut(PCOut), .PCOut_plus4(PCOut_plus4), .EPC(EPC),
        .ras_count(ras_count), .ras_pop_hit(ras_pop_hit)
    );

    pc_gen_unit #(.WIDTH(16), .RESET_VECTOR(16'hFFFC), .EXC_VECTOR(16'h4180), .RAS_DEPTH(4)) u_dut16 (
        .clk(clk), .PcReSet(PcReSet), .PCWrite(w16), .exc_req(zero1),
        .exc_pc(zero16), .eret_req(zero1), .redirect_valid(zero1),
        .redirect_pc(zero16), .ras_push(zero1), .ras_push_addr(zero16),
        .ras_pop(zero1), .PCOut(pc16), .PCOut_plus4(pc16_p4), .EPC(epc16),
        .ras_count(cnt16), .ras_pop_hit(hit16)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pw, exc, eret, rd, input logic [W-1:0] xpc, rpc,
                                input logic push, input logic [W-1:0] paddr, input logic pop,
                                input logic [W-1:0] e_pc, e_epc, input int e_cnt, input logic e_hit);
        vec_t t;
        t.pw = pw; t.exc = exc; t.eret = eret; t.rd = rd; t.xpc = xpc; t.rpc = rpc;
        t.push = push; t.paddr = paddr; t.pop = pop;
        t.e_pc = e_pc; t.e_epc = e_epc; t.e_cnt = e_cnt; t.e_hit = e_hit;
        return t;
    endfunction

    // driver tasks
    task automatic idle_inputs();
        PCWrite = 0; exc_req = 0; eret_req = 0; redirect_valid = 0; ras_push = 0; ras_pop = 0;
        exc_pc = '0; redirect_pc = '0; ras_push_addr = '0; w16 = 0;
    endtask

    task automatic apply(input vec_t t, input string tag);
        logic [W-1:0] exp_pc;
        @(negedge clk);
        PCWrite = t.pw; exc_req = t.exc; eret_req = t.eret; redirect_valid = t.rd;
        exc_pc = t.xpc; redirect_pc = t.rpc; ras_push = t.push; ras_push_addr = t.paddr;
        ras_pop = t.pop;
        #1;
        check({tag, " hit"}, W'(ras_pop_hit), W'(t.e_hit));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard queue empty", tag);
            exp_pc = '0;
        end else begin
            exp_pc = exp_q.pop_front();
        end
        check({tag, " pc"}, PCOut, exp_pc);
        check({tag, " plus4"}, PCOut_plus4, exp_pc + W'(4));
        check({tag, " epc"}, EPC, t.e_epc);
        check({tag, " count"}, W'(ras_count), W'(t.e_cnt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc"}, PCOut, 32'h3000);
        check({tag, " plus4"}, PCOut_plus4, 32'h3004);
        check({tag, " epc"}, EPC, '0);
        check({tag, " count"}, W'(ras_count), '0);
    endtask

    vec_t tbl[$];

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            exp_q.push_back(tbl[i].e_pc);
            apply(tbl[i], $sformatf("vec%0d", i));
        end
    endtask

    // reference model for the random phase
    logic [W-1:0] m_pc, m_epc;
    logic [W-1:0] m_ras[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        zero1 = 0; zero16 = '0;
        idle_inputs();
        PcReSet = 1;

        // segment A: 0..3
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h3004, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h3008, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h300C, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h777, 0, 32'h3010, 0, 1, 0));
        // segment B: 4..
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h3004, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h3008, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h300C, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h3010, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 0,32'h3043, 0,0, 0, 32'h3040, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0, 32'h3040, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 0, 32'h3040, 0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 0,0, 1,32'hAAA0, 0, 32'h3040, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3100, 0, 32'h3044, 0, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3200, 0, 32'h3048, 0, 2, 0));
        tbl.push_back(mk(1,0,0,1, 0,32'h3300, 0,0, 1, 32'h3300, 0, 2, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3200, 0, 1, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3100, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3104, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h10, 0, 32'h3108, 0, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h20, 0, 32'h310C, 0, 2, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h30, 0, 32'h3110, 0, 3, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h40, 0, 32'h3114, 0, 4, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h50, 0, 32'h3118, 0, 4, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h50, 0, 3, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h40, 0, 2, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h30, 0, 1, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h20, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h24, 0, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3100, 0, 32'h28, 0, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3200, 0, 32'h2C, 0, 2, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3500, 1, 32'h3200, 0, 2, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3500, 0, 1, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3100, 0, 0, 1));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3600, 0, 32'h3104, 0, 1, 0));
        tbl.push_back(mk(1,1,0,1, 32'h3024,32'h5000, 0,0, 1, 32'h4180, 32'h3024, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0, 32'h4184, 32'h3024, 1, 0));
        tbl.push_back(mk(0,0,1,0, 0,0, 0,0, 0, 32'h3024, 32'h3024, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3600, 32'h3024, 0, 1));
        tbl.push_back(mk(0,1,1,0, 32'h305B,0, 0,0, 0, 32'h4180, 32'h305B, 0, 0));
        tbl.push_back(mk(0,0,1,1, 0,32'h7000, 0,0, 0, 32'h3058, 32'h305B, 0, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 1,32'h3703, 1, 32'h305C, 32'h305B, 1, 0));
        tbl.push_back(mk(0,0,0,0, 0,0, 0,0, 1, 32'h305C, 32'h305B, 1, 0));
        tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 1, 32'h3700, 32'h305B, 0, 1));

        // power-on reset state
        #12;
        check_reset_state("por");
        check("por hit", W'(ras_pop_hit), '0);
        check("w16 reset pc", W'(pc16), W'(16'hFFFC));
        check("w16 reset plus4", W'(pc16_p4), W'(16'h0000));
        @(negedge clk);
        PcReSet = 0;

        // WIDTH=16 sequential wrap
        @(negedge clk);
        w16 = 1;
        @(posedge clk);
        #1;
        w16 = 0;
        check("w16 wrap pc", W'(pc16), W'(16'h0000));
        check("w16 wrap plus4", W'(pc16_p4), W'(16'h0004));
        check("w16 epc", W'(epc16), '0);
        check("w16 count", W'(cnt16) + W'(hit16), '0);
        // the extra idle edge held PCOut at 0x3000 on the main DUT
        check("hold before seq pc", PCOut, 32'h3000);

        run_table(0, 4);

        // asynchronous reset between clock edges
        @(negedge clk);
        PCWrite = 1;
        #2;
        PcReSet = 1;
        #1;
        check_reset_state("async rst");
        @(posedge clk);
        #1;
        check("rst held pc", PCOut, 32'h3000);
        @(negedge clk);
        PcReSet = 0;
        PCWrite = 0;

        run_table(4, tbl.size());

        // re-sync for the random phase
        @(negedge clk);
        idle_inputs();
        PcReSet = 1;
        #1;
        check_reset_state("rand rst");
        @(negedge clk);
        PcReSet = 0;
        @(posedge clk);
        #1;
        m_pc = 32'h3000; m_epc = '0; m_ras = {};

        for (int i = 0; i < 400; i++) begin
            vec_t t;
            logic hit, ras_upd;
            logic [W-1:0] np;
            t.pw = ($urandom_range(0, 3) != 0);
            t.exc = ($urandom_range(0, 15) == 0);
            t.eret = ($urandom_range(0, 9) == 0);
            t.rd = ($urandom_range(0, 7) == 0);
            t.push = ($urandom_range(0, 2) == 0);
            t.pop = ($urandom_range(0, 2) == 0);
            t.xpc = $urandom;
            t.rpc = $urandom;
            t.paddr = $urandom;

            ras_upd = t.pw && !t.exc && !t.eret && !t.rd;
            hit = ras_upd && t.pop && (m_ras.size() > 0);
            if (t.exc) np = 32'h4180;
            else if (t.eret) np = m_epc & ~32'h3;
            else if (t.rd) np = t.rpc & ~32'h3;
            else if (hit) np = m_ras[m_ras.size() - 1] & ~32'h3;
            else if (t.pw) np = m_pc + 32'd4;
            else np = m_pc;
            if (t.exc) m_epc = t.xpc;
            if (ras_upd) begin
                if (t.push && t.pop && m_ras.size() > 0) begin
                    m_ras[m_ras.size() - 1] = t.paddr;
                end else if (t.push) begin
                    m_ras.push_back(t.paddr);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (t.pop && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
            m_pc = np;

            t.e_pc = np; t.e_epc = m_epc; t.e_cnt = m_ras.size(); t.e_hit = hit;
            exp_q.push_back(np);
            apply(t, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the pipelined core's IF stage. It holds the current PC and its +4 successor, and selects the next PC by fixed priority from these sources:
- exception vector
- exception return (EPC)
- EX-stage branch/jump redirect
- return-address-stack (RAS) prediction
- sequential fetch

It owns the EPC register and a circular RAS, so ID-stage calls and returns are predicted without waiting for EX.

Parameters:
WIDTH, 32, PC/address width in bits (>=8)
RESET_VECTOR, 32'h0000_3000, PC loaded on reset
EXC_VECTOR, 32'h0000_4180, PC loaded on exception
RAS_DEPTH, 4, RAS entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
PcReSet  in  1  asynchronous active-high reset
PCWrite  in  1  1 = advance PC; 0 = stall (hold)
exc_req  in  1  exception taken this cycle
exc_pc  in  WIDTH  PC of faulting instruction, captured into EPC
eret_req  in  1  return from exception
redirect_valid  in  1  EX-resolved branch/jump taken or mispredict fix
redirect_pc  in  WIDTH  redirect target
ras_push  in  1  ID decoded a call (jal/jalr)
ras_push_addr  in  WIDTH  return address to push
ras_pop  in  1  ID decoded a return (jr $ra); use RAS prediction
PCOut  out  WIDTH  current fetch PC
PCOut_plus4  out  WIDTH  PCOut+4
EPC  out  WIDTH  saved exception PC
ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
ras_pop_hit  out  1  comb: ras_pop && ras_count!=0 && PCWrite && no higher source

Behaviour:
Reset (async on PcReSet high):
- PCOut = RESET_VECTOR; PCOut_plus4 = RESET_VECTOR+4
- EPC = 0; ras_count = 0; RAS pointer = 0; RAS contents don't-care

Registration:
- All state is registered; the next PC is visible one cycle after the deciding edge.
- PCOut_plus4 always equals PCOut+4 modulo 2^WIDTH. It is registered alongside PCOut, never computed late.

Next-PC priority, evaluated at posedge:
1. exc_req → EXC_VECTOR; EPC <= exc_pc.
2. eret_req → EPC (the old value). If exc_req=1 in the same cycle, exc_req wins and the eret is dropped.
3. redirect_valid → redirect_pc.
4. PCWrite && ras_pop && ras_count!=0 → RAS top.
5. PCWrite → PCOut_plus4.
6. Otherwise hold.

Stall override:
- Sources 1–3 override a stall: they act even when PCWrite=0, because the pipeline is flushing.

Address alignment:
- Loaded targets (redirect_pc, RAS top, EPC, vectors) have bits [1:0] forced to 0.
- Sequential +4 wraps at 2^WIDTH with no flag.

RAS update rules:
- RAS updates are enabled only when PCWrite=1 and none of exc_req/eret_req/redirect_valid is asserted. Otherwise push/pop are ignored and the RAS is unchanged.
- Push only: write ras_push_addr at ptr, ptr+1 (mod RAS_DEPTH), count = min(count+1, RAS_DEPTH).
- Push when full: overwrite the oldest entry via circular wrap; count stays RAS_DEPTH.
- Pop only, count>0: next PC = top; ptr-1; count-1.
- Pop when empty: ignored. PC goes sequential, ras_pop_hit=0, count stays 0.
- Push and pop together, count>0: next PC = old top; top entry replaced by ras_push_addr; ptr and count unchanged.
- Push and pop together, count=0: treated as push only; PC sequential.

Exception handling:
- An exception or redirect does not clear the RAS; stale entries are tolerated as mispredictions.
- EPC changes only on exc_req or reset.

Reset mid-operation:
- PcReSet asserted at any time forces the reset values immediately, independent of clk, and holds them while high.
- The first update happens on the first clk edge after deassertion.

Test Plan:
1. Reset, then PCWrite=1 for 3 cycles → PCOut 0x3000, 0x3004, 0x3008, 0x300C; PCOut_plus4 always PCOut+4. PcReSet pulse mid-cycle → PCOut=0x3000 without a clock edge.
2. PCOut=0x3010, PCWrite=0, redirect_valid=1, redirect_pc=0x3043 → next PCOut=0x3040. With PCWrite=0 and no redirect → PCOut holds for 2 cycles.
3. Push 0x3100, 0x3200; then ras_pop at PCOut=0x3300 → next PCOut=0x3200, ras_count 2→1. Pop again → 0x3100, count 0. Third pop → sequential +4, ras_pop_hit=0.
4. Push 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH=4) → count=4. Four pops return 0x50, 0x40, 0x30, 0x20, then an empty pop is ignored.
5. Same cycle: exc_req=1, exc_pc=0x3024, redirect_valid=1, ras_pop=1 → PCOut=0x4180, EPC=0x3024, RAS unchanged. Later eret_req=1 → PCOut=0x3024. exc_req+eret_req together → PCOut=0x4180 and EPC updated.
6. count=2, top=0x3200, push 0x3500 together with pop → next PCOut=0x3200, top becomes 0x3500, count=2. WIDTH=16 run: PCOut 0xFFFC, +4 → 0x0000.
